// File: rtl/fft_sample_loader_pkg.sv
// Shared FFT defaults and the sample-loader state encoding.
package fft_sample_loader_pkg;

  localparam int unsigned DefWordSize   = 16;
  localparam int unsigned DefAddrSize   = 3;
  localparam int unsigned DefNumSamples = 32;

  typedef enum logic [1:0] {
    StFill,
    StFull,
    StLoad,
    StHandshake
  } loader_state_e;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample-stream and RAM-load bundle between the sample loader and its environment.
interface fft_sample_loader_if
  import fft_sample_loader_pkg::*;
#(
  parameter int unsigned WORDSIZE = DefWordSize,
  parameter int unsigned ADDRSIZE = DefAddrSize
) ();

  logic [WORDSIZE-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic                ld_data;
  logic                ld_done;
  logic                ld_valid;
  logic [ADDRSIZE-1:0] ld_addr;
  logic [WORDSIZE-1:0] data_in0;
  logic [WORDSIZE-1:0] data_in1;
  logic [WORDSIZE-1:0] data_in2;
  logic [WORDSIZE-1:0] data_in3;
  logic                frame_full;

  // The loader's own view.
  modport master (
    input  s_data, s_valid, ld_data,
    output s_ready, ld_done, ld_valid, ld_addr,
    output data_in0, data_in1, data_in2, data_in3, frame_full
  );

  // Sample source and FFT top-level view.
  modport slave (
    output s_data, s_valid, ld_data,
    input  s_ready, ld_done, ld_valid, ld_addr,
    input  data_in0, data_in1, data_in2, data_in3, frame_full
  );

endinterface

// File: rtl/sample_bank_buffer.sv
// Frame store: 4 lanes x NUMSAMPLES/4 words, one write port, 4-wide read at one address.
module sample_bank_buffer
  import fft_sample_loader_pkg::*;
#(
  parameter int unsigned WORDSIZE   = DefWordSize,
  parameter int unsigned ADDRSIZE   = DefAddrSize,
  parameter int unsigned NUMSAMPLES = DefNumSamples
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [1:0]               wr_lane,
  input  logic [ADDRSIZE-1:0]      wr_addr,
  input  logic [WORDSIZE-1:0]      wr_data,
  input  logic [ADDRSIZE-1:0]      rd_addr,
  output logic [3:0][WORDSIZE-1:0] rd_data
);

  localparam int unsigned Depth = NUMSAMPLES / 4;

  logic [WORDSIZE-1:0] mem [4][Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_lane][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int l = 0; l < 4; l++) begin
      rd_data[l] = mem[l][rd_addr];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Buffers one frame of serial samples and streams it four words per cycle into the FFT RAM banks.
module fft_sample_loader
  import fft_sample_loader_pkg::*;
#(
  parameter int unsigned WORDSIZE   = DefWordSize,
  parameter int unsigned ADDRSIZE   = DefAddrSize,
  parameter int unsigned NUMSAMPLES = DefNumSamples
) (
  input logic                 clk,
  input logic                 rst,
  fft_sample_loader_if.master bus
);

  localparam int unsigned NumGroups = NUMSAMPLES / 4;
  localparam int unsigned CntW      = $clog2(NUMSAMPLES) + 1;

  localparam logic [CntW-1:0]     LastSample = CntW'(NUMSAMPLES - 1);
  localparam logic [ADDRSIZE-1:0] LastGroup  = ADDRSIZE'(NumGroups - 1);

  loader_state_e                state_q, state_d;
  logic [CntW-1:0]              fill_cnt_q, fill_cnt_d;
  logic [ADDRSIZE-1:0]          grp_q, grp_d;
  logic                         s_ready_q;
  logic                         frame_full_q;
  logic                         ld_done_q, ld_done_d;
  logic                         ld_valid_q, ld_valid_d;
  logic [ADDRSIZE-1:0]          ld_addr_q, ld_addr_d;
  logic [3:0][WORDSIZE-1:0]     data_q, data_d;
  logic [3:0][WORDSIZE-1:0]     rd_data;
  logic                         accept;

  // s_ready_q is only ever high in FILL, so it gates acceptance on its own.
  assign accept = bus.s_valid && s_ready_q;

  sample_bank_buffer #(
    .WORDSIZE  (WORDSIZE),
    .ADDRSIZE  (ADDRSIZE),
    .NUMSAMPLES(NUMSAMPLES)
  ) u_buffer (
    .clk    (clk),
    .we     (accept),
    .wr_lane(fill_cnt_q[1:0]),
    .wr_addr(fill_cnt_q[ADDRSIZE+1:2]),
    .wr_data(bus.s_data),
    .rd_addr(grp_q),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    grp_d      = grp_q;
    ld_done_d  = ld_done_q;
    ld_valid_d = 1'b0;
    ld_addr_d  = ld_addr_q;
    data_d     = data_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LastSample) state_d = StFull;
        end
      end
      StFull: begin
        if (bus.ld_data) begin
          state_d = StLoad;
          grp_d   = '0;
        end
      end
      StLoad: begin
        if (!bus.ld_data) begin
          // Aborted load: keep the frame, restart from group 0 on the next request.
          state_d = StFull;
          grp_d   = '0;
        end else begin
          ld_valid_d = 1'b1;
          ld_addr_d  = grp_q;
          data_d     = rd_data;
          if (grp_q == LastGroup) begin
            grp_d   = '0;
            state_d = StHandshake;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      StHandshake: begin
        if (!bus.ld_data) begin
          state_d    = StFill;
          ld_done_d  = 1'b0;
          fill_cnt_d = '0;
        end else begin
          ld_done_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      fill_cnt_q   <= '0;
      grp_q        <= '0;
      s_ready_q    <= 1'b0;
      frame_full_q <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_addr_q    <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      grp_q        <= grp_d;
      s_ready_q    <= (state_d == StFill);
      frame_full_q <= (state_d != StFill);
      ld_done_q    <= ld_done_d;
      ld_valid_q   <= ld_valid_d;
      ld_addr_q    <= ld_addr_d;
      data_q       <= data_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.frame_full = frame_full_q;
  assign bus.ld_done    = ld_done_q;
  assign bus.ld_valid   = ld_valid_q;
  assign bus.ld_addr    = ld_addr_q;
  assign bus.data_in0   = data_q[0];
  assign bus.data_in1   = data_q[1];
  assign bus.data_in2   = data_q[2];
  assign bus.data_in3   = data_q[3];

endmodule

// File: tb/tb_fft_sample_loader.sv
// Randomised bench for fft_sample_loader against a frame-array reference model.
module tb_fft_sample_loader;
  import fft_sample_loader_pkg::*;

  localparam int unsigned W = DefWordSize;
  localparam int unsigned A = DefAddrSize;
  localparam int unsigned N = DefNumSamples;
  localparam int unsigned G = N / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_sample_loader_if #(.WORDSIZE(W), .ADDRSIZE(A)) bus ();

  fft_sample_loader #(
    .WORDSIZE  (W),
    .ADDRSIZE  (A),
    .NUMSAMPLES(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: samples in the order the loader accepted them.
  logic [W-1:0] frame [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_group(input int g);
    return {frame[4*g+3], frame[4*g+2], frame[4*g+1], frame[4*g]};
  endfunction

  function automatic logic [63:0] dut_group();
    return {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {bus.s_ready, bus.ld_done, bus.ld_valid, bus.ld_addr, bus.frame_full};
  endfunction

  // Feeds one frame; ends on the negedge just after the final accepted sample.
  task automatic fill_frame(input logic [W-1:0] base, input bit rnd, input int ld_at,
                            input bit gaps);
    int n   = 0;
    int cyc = 0;
    bit acc;
    while (n < N && cyc < 1000) begin
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data  = rnd ? W'($urandom) : base + W'(n);
      if (n == ld_at) bus.ld_data = 1'b1;
      acc = bus.s_valid && bus.s_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        frame[n] = bus.s_data;
        n++;
      end
      if (bus.ld_data) check("pending_no_valid", bus.ld_valid, 1'b0);
    end
    check("fill_count", 64'(n), 64'(N));
    // s_valid stays high across the next edge: nothing more may be taken.
    check("full_flag", bus.frame_full, 1'b1);
    check("full_not_ready", bus.s_ready, 1'b0);
  endtask

  // From FULL: request, check the whole burst, then complete the handshake.
  task automatic load_burst();
    bus.ld_data = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("load_latency", bus.ld_valid, 1'b0);
    for (int g = 0; g < G; g++) begin
      @(negedge clk);
      check("grp_valid", bus.ld_valid, 1'b1);
      check("grp_addr", bus.ld_addr, 64'(g));
      check("grp_data", dut_group(), exp_group(g));
      check("grp_no_done", bus.ld_done, 1'b0);
    end
    @(negedge clk);
    check("done_rise", bus.ld_done, 1'b1);
    check("done_no_valid", bus.ld_valid, 1'b0);
    check("done_hold_data", dut_group(), exp_group(G - 1));
    @(negedge clk);
    check("done_held", bus.ld_done, 1'b1);
    bus.ld_data = 1'b0;
    @(negedge clk);
    check("done_fall", bus.ld_done, 1'b0);
    check("refill_ready", bus.s_ready, 1'b1);
    check("refill_not_full", bus.frame_full, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.ld_data = 1'b0;
    #1;
    check("reset_outputs", all_outputs(), '0);
    check("reset_data", dut_group(), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.s_ready, 1'b1);

    // Counting frame, request raised in FULL.
    fill_frame(16'h0000, 1'b0, -1, 1'b0);
    load_burst();

    // Second counting frame straight after the handshake.
    fill_frame(16'h0100, 1'b0, -1, 1'b0);
    load_burst();

    // Request raised mid-fill is held until the frame is complete.
    fill_frame('0, 1'b1, 20, 1'b1);
    load_burst();

    // Abort after group 2, then replay from group 0.
    fill_frame('0, 1'b1, -1, 1'b1);
    bus.ld_data = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int g = 0; g < 3; g++) @(negedge clk);
    check("abort_pre_addr", bus.ld_addr, 64'd2);
    bus.ld_data = 1'b0;
    @(negedge clk);
    check("abort_no_valid", bus.ld_valid, 1'b0);
    check("abort_keep_full", bus.frame_full, 1'b1);
    check("abort_hold_data", dut_group(), exp_group(2));
    @(negedge clk);
    check("abort_idle", {bus.ld_valid, bus.ld_done, bus.s_ready}, '0);
    load_burst();

    // Reset during group 4.
    fill_frame('0, 1'b1, -1, 1'b0);
    bus.ld_data = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int g = 0; g < 5; g++) @(negedge clk);
    check("pre_reset_addr", bus.ld_addr, 64'd4);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), '0);
    check("async_reset_data", dut_group(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_valid", bus.ld_valid, 1'b0);
      check("post_reset_empty", bus.frame_full, 1'b0);
    end
    fill_frame('0, 1'b1, -1, 1'b0);
    load_burst();

    // A few more random frames with gaps.
    for (int r = 0; r < 3; r++) begin
      fill_frame('0, 1'b1, int'($urandom_range(0, N + 4)), 1'b1);
      load_burst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
